// File: rtl/toggle_merger.sv
// toggle_merger: merges two toggle-encoded SFQ pulse streams into one
// toggle-encoded output. Simultaneous pulses are queued in a saturating
// pending counter and drained at one output toggle per cycle. Collisions
// are counted, and lost pulses raise a sticky overflow flag. Input
// transitions seen during the post-reset hold-off window are absorbed.
module toggle_merger #(
    parameter int CNT_W   = 4,
    parameter int COLL_W  = 8,
    parameter int HOLDOFF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in1,
    input  logic              in2,
    output logic              out,
    output logic [CNT_W-1:0]  pending,
    output logic [COLL_W-1:0] collisions,
    output logic              overflow,
    output logic              idle
);

    localparam int HC_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLDOFF - 1);
    localparam logic [CNT_W:0]  PEND_MAX  = {1'b0, {CNT_W{1'b1}}};

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [HC_W-1:0]    hold_cnt_reg;
    logic               out_reg;
    logic [CNT_W-1:0]   pending_reg;
    logic [COLL_W-1:0]  collisions_reg;
    logic               overflow_reg;

    logic [1:0]         in_vec;
    logic [1:0]         in_q_reg;
    logic [1:0]         event_vec;

    logic [1:0]         arrivals;
    logic               emit;
    logic [CNT_W:0]     sum_next;

    assign in_vec = {in2, in1};

    // Per-input delay register and transition detector; the previous level
    // is tracked in every state so hold-off transitions are absorbed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            // Capture the previous input level on every edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_q_reg[gi] <= 1'b0;
                end else begin
                    in_q_reg[gi] <= in_vec[gi];
                end
            end
            assign event_vec[gi] = in_vec[gi] ^ in_q_reg[gi];
        end
    endgenerate

    // Arrivals, emission decision and the widened next pending sum.
    always_comb begin
        arrivals = {1'b0, event_vec[0]} + {1'b0, event_vec[1]};
        emit     = (pending_reg != '0);
        sum_next = {1'b0, pending_reg} + (CNT_W + 1)'(arrivals)
                   - (CNT_W + 1)'(emit);
    end

    // Hold-off / run sequencing with the merge datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= HOLD;
            hold_cnt_reg   <= '0;
            out_reg        <= 1'b0;
            pending_reg    <= '0;
            collisions_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (emit) begin
                        out_reg <= ~out_reg;
                    end
                    if (sum_next > PEND_MAX) begin
                        pending_reg  <= '1;
                        overflow_reg <= 1'b1;
                    end else begin
                        pending_reg <= sum_next[CNT_W-1:0];
                    end
                    if (event_vec[0] && event_vec[1] && (collisions_reg != '1)) begin
                        collisions_reg <= collisions_reg + 1'b1;
                    end
                end
                default: state_reg <= HOLD;
            endcase
        end
    end

    assign out        = out_reg;
    assign pending    = pending_reg;
    assign collisions = collisions_reg;
    assign overflow   = overflow_reg;
    assign idle       = (state_reg == RUN) && (pending_reg == '0) && (event_vec == 2'b00);

endmodule

// File: tb/tb_toggle_merger.sv
// Testbench for toggle_merger: directed scenarios followed by random toggle
// traffic with occasional resets, compared against a pulse-counting model.
module tb_toggle_merger;

    localparam int CNT_W   = 2;
    localparam int COLL_W  = 3;
    localparam int HOLDOFF = 2;
    localparam int PMAX    = (1 << CNT_W) - 1;
    localparam int CMAX    = (1 << COLL_W) - 1;

    logic              clk;
    logic              rst;
    logic              in1;
    logic              in2;
    logic              out;
    logic [CNT_W-1:0]  pending;
    logic [COLL_W-1:0] collisions;
    logic              overflow;
    logic              idle;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pulses are plain integers.
    int m_q1, m_q2;       // last sampled input levels
    int m_edges;          // edges since reset release (saturates at HOLDOFF)
    int m_pend;           // pulses waiting
    int m_emitted;        // total pulses emitted since reset
    int m_coll;           // collision count
    int m_ovf;            // any pulse lost
    int m_lost;           // pulses discarded

    toggle_merger #(
        .CNT_W  (CNT_W),
        .COLL_W (COLL_W),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .pending   (pending),
        .collisions(collisions),
        .overflow  (overflow),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0; m_edges = 0; m_pend = 0;
        m_emitted = 0; m_coll = 0; m_ovf = 0;
    endtask

    function automatic int model_run();
        return (m_edges >= HOLDOFF) ? 1 : 0;
    endfunction

    // One clock edge of the model using the levels currently on in1/in2.
    task automatic model_edge();
        int e1, e2, total;
        e1 = (int'(in1) != m_q1) ? 1 : 0;
        e2 = (int'(in2) != m_q2) ? 1 : 0;
        if (m_edges < HOLDOFF) begin
            m_edges++;
        end else begin
            total = m_pend + e1 + e2;
            if (m_pend > 0) begin
                m_emitted++;
                total--;
            end
            if (total > PMAX) begin
                m_lost += total - PMAX;
                m_ovf = 1;
                total = PMAX;
            end
            m_pend = total;
            if (e1 == 1 && e2 == 1 && m_coll < CMAX) m_coll++;
        end
        m_q1 = int'(in1);
        m_q2 = int'(in2);
    endtask

    task automatic check_all(input string when);
        check({"out_", when},        32'(out),        32'(m_emitted % 2));
        check({"pending_", when},    32'(pending),    32'(m_pend));
        check({"collisions_", when}, 32'(collisions), 32'(m_coll));
        check({"overflow_", when},   32'(overflow),   32'(m_ovf));
    endtask

    // Drive new levels, check idle with the event present, then clock.
    task automatic step(input logic a, input logic b);
        int exp_idle;
        in1 = a;
        in2 = b;
        #1;
        exp_idle = (model_run() == 1 && m_pend == 0 && int'(a) == m_q1 && int'(b) == m_q2) ? 1 : 0;
        check("idle_pre", 32'(idle), 32'(exp_idle));
        @(posedge clk);
        #1;
        model_edge();
        check_all("edge");
        check("idle_post", 32'(idle), 32'((model_run() == 1 && m_pend == 0) ? 1 : 0));
        $display("step in1=%0b in2=%0b out=%0b pending=%0d coll=%0d ovf=%0b idle=%0b",
                 a, b, out, pending, collisions, overflow, idle);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        check("idle_rst", 32'(idle), 32'(0));
        $display("reset asserted in1=%0b in2=%0b", in1, in2);
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        m_lost = 0;
        in1 = 1'b1;
        in2 = 1'b1;
        rst = 1'b1;
        #2;
        do_reset();

        // Inputs sitting at 1 across release: absorbed by hold-off.
        repeat (4) step(1'b1, 1'b1);

        // Toggle in1 during both hold-off cycles.
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b1);

        // Single pulse in RUN.
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b1);

        // Collision.
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);

        // Overflow: both toggle on 3 consecutive edges.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("lost_pulses", 32'(overflow), 32'(m_lost > 0 ? 1 : 0));
        repeat (5) step(1'b0, 1'b1);

        // Reset mid-drain with pending at 3.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("pending_before_rst", 32'(pending), 32'(3));
        do_reset();
        repeat (5) step(1'b0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(in1 ^ 1'($urandom_range(0, 1)), in2 ^ 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
